// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM.
// Holds the FSM state type, read-during-write mode constants and lane merge.
package ram_pkg;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic logic [7:0] lane_merge(
        input logic       en,
        input logic [7:0] new_b,
        input logic [7:0] old_b
    );
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Init sequencer: fills the array with INIT_VAL after reset or clr.
// Ports: clk_i/rst_ni, user write/read strobes in; muxed array write, rd_en_o, init_done_o out.
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                re_i,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic                rd_en_o,
    output logic                init_done_o
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_we_o   = 1'b0;
        mem_be_o   = '0;
        mem_addr_o = waddr_i;
        mem_data_o = wdata_i;
        rd_en_o    = 1'b0;
        unique case (state_q)
            S_INIT: begin
                mem_we_o   = 1'b1;
                mem_be_o   = '1;
                mem_addr_o = cnt_q[ADDR_W-1:0];
                mem_data_o = INIT_VAL;
                cnt_d      = cnt_q + (ADDR_W+1)'(1);
                // MSB sets once the write to DEPTH-1 is issued
                if (cnt_d[ADDR_W]) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (clr_i) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end else begin
                    mem_we_o = we_i;
                    mem_be_o = be_i;
                    rd_en_o  = re_i;
                end
            end
        endcase
    end

    assign init_done_o = (state_q == S_READY);

endmodule

// File: rtl/ram_sdp.sv
// Simple-dual-port RAM with byte enables, RDW mode, optional output reg.
// Ports: write port (we/be/write_addr/data), read port (re/read_addr/out/rd_valid), clr, init_done.
module ram_sdp
    import ram_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter int                OUT_REG  = 0,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic [DATA_W-1:0]   data,
    input  logic                re,
    input  logic [ADDR_W-1:0]   read_addr,
    output logic [DATA_W-1:0]   out,
    output logic                rd_valid,
    output logic                init_done
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int BE_W  = DATA_W/8;

    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              rd_en;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] old_w;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              rvalid_q;

    ram_init_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_VAL (INIT_VAL)
    ) u_ctrl (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .we_i        (we),
        .be_i        (be),
        .waddr_i     (write_addr),
        .wdata_i     (data),
        .re_i        (re),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data),
        .rd_en_o     (rd_en),
        .init_done_o (init_done)
    );

    // Array has no reset; the init sequencer is what clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
                end
            end
        end
    end

    // Plain array read gives old data; new-data mode forwards enabled lanes.
    always_comb begin
        old_w   = mem_q[read_addr];
        rdata_d = old_w;
        if (RDW_MODE == RDW_NEW && mem_we && mem_addr == read_addr) begin
            for (int i = 0; i < BE_W; i++) begin
                rdata_d[8*i +: 8] = lane_merge(mem_be[i],
                                               mem_data[8*i +: 8],
                                               old_w[8*i +: 8]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rdata_d;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] pdata_q;
        logic              pvalid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pdata_q  <= '0;
                pvalid_q <= 1'b0;
            end else begin
                pvalid_q <= rvalid_q;
                if (rvalid_q) begin
                    pdata_q <= rdata_q;
                end
            end
        end

        assign out      = pdata_q;
        assign rd_valid = pvalid_q;
    end else begin : g_noreg
        assign out      = rdata_q;
        assign rd_valid = rvalid_q;
    end

endmodule

// File: doc/ram_sdp.md
# ram_sdp

Parametrised simple-dual-port synchronous RAM, the successor to the fixed 64x8 single-port RAM. One write port and one read port operate in the same cycle. The block adds byte-lane write enables, a selectable read-during-write result, an optional output register, and a hardware initialisation sequencer that fills the array after reset or on request. It sits behind datapath blocks that need local operand or sample storage.

## Interface
- `DATA_W`, default 8: word width; must be a multiple of 8.
- `ADDR_W`, default 6: address width; `DEPTH = 2**ADDR_W`.
- `OUT_REG`, default 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- `RDW_MODE`, default 0: same-address read/write collision result; 0 = old data, 1 = new data.
- `INIT_VAL`, default 0: `DATA_W`-bit value written to every word during initialisation.

Ports:
- `clk` in, 1: single clock; all logic on the rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `clr` in, 1: pulse that restarts initialisation.
- `we` in, 1: write strobe.
- `be` in, `DATA_W/8`: byte-lane enables, bit i covers `data[8i+7:8i]`.
- `write_addr` in, `ADDR_W`: write address.
- `data` in, `DATA_W`: write data.
- `re` in, 1: read strobe.
- `read_addr` in, `ADDR_W`: read address.
- `out` out, `DATA_W`: read data.
- `rd_valid` out, 1: `out` holds the result of a read accepted `1+OUT_REG` cycles earlier.
- `init_done` out, 1: array initialised; ports accepted.

## Operation
- FSM states `S_INIT` and `S_READY`.
- **Reset** (`rst_n` low):
  - FSM goes to `S_INIT` and the init counter to 0.
  - `out`, the pipeline register, `rd_valid` and `init_done` all go to 0.
  - The array itself is not reset; only the init sequence clears it.
- **`S_INIT`:**
  - Each cycle writes `INIT_VAL` to address `cnt`, then increments `cnt`.
  - After the write to `DEPTH-1`, the FSM moves to `S_READY` and `init_done` goes to 1.
  - `we`, `re` and `clr` are ignored; `rd_valid` stays 0.
- **`S_READY`:**
  - A `clr` pulse takes the FSM to `S_INIT` with `cnt=0` and `init_done=0`.
  - Any read already in the output pipeline still completes.
- **Write** (`S_READY`, `we=1`): for each lane i with `be[i]=1`, the array lane is updated with the matching data byte. Other lanes are unchanged. `we=1` with `be=0` is a no-op.
- **Read** (`S_READY`, `re=1`): reads `read_addr`. When `re=0`, `out` holds its last value and `rd_valid` is 0 in the corresponding cycle.
- **Simultaneous read and write** are both performed, unlike the previous block, where a write blocked the read.
- **Collision** (`re` and `we` at the same address in the same cycle):
  - `RDW_MODE=0`: return the pre-write word.
  - `RDW_MODE=1`: return a merge of the enabled lanes from `data` and the other lanes from the old word.
- **`clr` on the same cycle as `we`/`re`:** `clr` wins; the write and read are dropped.
- **Addresses** are `ADDR_W` bits wide, so no out-of-range case exists. `cnt` is `ADDR_W+1` bits so it detects its terminal count without wrapping.

## Timing
- **Init duration:** exactly `DEPTH` cycles.
  - First init write on the first edge after `rst_n` rises.
  - `init_done` is high on the edge after the write to `DEPTH-1`.
  - A write or read asserted in that cycle is accepted.
- **Read latency `OUT_REG=0`:** `re` sampled at edge N; `out` and `rd_valid` are valid after edge N.
- **Read latency `OUT_REG=1`:** valid after edge N+1. Back-to-back reads give one result per cycle.
- **Write-to-read:** a write at edge N is visible to a different-address or later read issued at edge N+1.
- **Reset mid-operation:** asserting `rst_n` during `S_INIT` or during a read in flight clears all outputs immediately. Init then restarts from address 0.

## Structure
- **Package `ram_pkg`:**
  - FSM state typedef (`S_INIT`, `S_READY`).
  - Constants `RDW_OLD=0` and `RDW_NEW=1`.
  - Helper function for the byte-lane merge.
- **Sub-module `ram_init_ctrl`:** FSM, counter, and mux of init versus user write signals. The array, collision logic and output pipeline stay in `ram_sdp`.

## Test plan
- **Init fill:** release reset with `DATA_W=8`, `ADDR_W=6`, `INIT_VAL=8'hA5`. Expect `init_done` rising after 64 cycles; reads of addresses 0, 31 and 63 return `8'hA5`.
- **Byte enables:** `DATA_W=32`, write `32'h11223344` to address 5 with `be=4'b1111`, then `32'hAABBCCDD` with `be=4'b0101`. Expect read of 5 = `32'h11BB33DD`.
- **Latency and streaming:** `OUT_REG=1`, read addresses 1, 2, 3 back-to-back. Expect `rd_valid` high for 3 consecutive cycles starting 2 cycles after the first `re`, with data in order.
- **Collision:** address 9 holds `8'h10`; same cycle `we` with `8'h20` and `re`, both at 9. Expect `8'h10` for `RDW_MODE=0` and `8'h20` for `RDW_MODE=1`.
- **Clear mid-stream:** write `8'h77` to address 3, then pulse `clr` together with `we`. Expect the write dropped, `init_done=0` for 64 cycles, and address 3 then reading `INIT_VAL`.
- **Reset mid-init:** assert `rst_n` low at init cycle 20. Expect `out=0`, `rd_valid=0` and `init_done=0` immediately; after release, init takes the full 64 cycles.
